// File: rtl/ext_lights.sv
// Exterior-light controller: a registered on/off state with hysteresis between
// the turn-on and turn-off brightness thresholds.
module ext_lights #(
  parameter int unsigned ON_THRESHOLD  = 50,
  parameter int unsigned OFF_THRESHOLD = 60
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [7:0] Lum_sen,
  output logic       Ext_light
);

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } state_e;

  localparam logic [7:0] OnThr  = 8'(ON_THRESHOLD);
  localparam logic [7:0] OffThr = 8'(OFF_THRESHOLD);

  state_e stateQ;
  state_e stateD;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stateQ <= OFF;
    end else begin
      stateQ <= stateD;
    end
  end

  // Readings inside the inclusive band OnThr..OffThr leave the state untouched.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      OFF: if (Lum_sen < OnThr)  stateD = ON;
      ON:  if (Lum_sen > OffThr) stateD = OFF;
      default: stateD = OFF;
    endcase
  end

  always_comb begin
    Ext_light = (stateQ == ON);
  end

endmodule

// File: tb/tb_ext_lights.sv
// Scoreboard bench for ext_lights: expected light levels are queued as each
// reading is driven and compared one clock edge later.
module tb_ext_lights;

  logic       clk;
  logic       rstN;
  logic [7:0] lum;
  logic [7:0] lum100;
  logic       light;
  logic       light100;

  int checks;
  int errors;
  logic expQ[$];

  ext_lights dut (
    .CLK      (clk),
    .Reset    (rstN),
    .Lum_sen  (lum),
    .Ext_light(light)
  );

  ext_lights #(
    .ON_THRESHOLD (100),
    .OFF_THRESHOLD(100)
  ) dut100 (
    .CLK      (clk),
    .Reset    (rstN),
    .Lum_sen  (lum100),
    .Ext_light(light100)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    logic want;
    rstN   = 1'b0;
    lum    = 8'd20;
    lum100 = 8'd200;
    #1;
    checks++;
    if (light !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async got %b want 0", light);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (light !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold got %b want 0", light);
    end
    lum  = 8'd90;
    rstN = 1'b1;
    expQ.push_back(1'b0);
    @(posedge clk);
    #1;
    want = expQ.pop_front();
    checks++;
    if (light !== want) begin
      errors++;
      $display("[TB] FAIL reset_release got %b want %b", light, want);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] lumTab[3] = '{8'd90, 8'd20, 8'd90};
    logic       expTab[3] = '{1'b0, 1'b1, 1'b0};
    logic want;
    for (int i = 0; i < 3; i++) begin
      lum = lumTab[i];
      expQ.push_back(expTab[i]);
      @(posedge clk);
      #1;
      want = expQ.pop_front();
      checks++;
      if (light !== want) begin
        errors++;
        $display("[TB] FAIL sequence[%0d] lum=%0d got %b want %b", i, lumTab[i], light, want);
      end
    end
  endtask

  task automatic test_hysteresis();
    logic [7:0] lumTab[8] = '{8'd50, 8'd55, 8'd60, 8'd49, 8'd50, 8'd55, 8'd60, 8'd61};
    logic       expTab[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic want;
    for (int i = 0; i < 8; i++) begin
      lum = lumTab[i];
      expQ.push_back(expTab[i]);
      @(posedge clk);
      #1;
      want = expQ.pop_front();
      checks++;
      if (light !== want) begin
        errors++;
        $display("[TB] FAIL hysteresis[%0d] lum=%0d got %b want %b", i, lumTab[i], light, want);
      end
    end
  endtask

  // Each extreme is checked both before its edge (old value held) and after.
  task automatic test_extremes();
    logic [7:0] lumTab[2] = '{8'd0, 8'd255};
    logic       expTab[2] = '{1'b1, 1'b0};
    logic want;
    for (int i = 0; i < 2; i++) begin
      lum = lumTab[i];
      expQ.push_back(expTab[i]);
      #1;
      checks++;
      if (light !== ~expTab[i]) begin
        errors++;
        $display("[TB] FAIL extreme_early[%0d] lum=%0d got %b want %b", i, lumTab[i], light, ~expTab[i]);
      end
      @(posedge clk);
      #1;
      want = expQ.pop_front();
      checks++;
      if (light !== want) begin
        errors++;
        $display("[TB] FAIL extreme[%0d] lum=%0d got %b want %b", i, lumTab[i], light, want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic want;
    lum = 8'd20;
    expQ.push_back(1'b1);
    @(posedge clk);
    #1;
    want = expQ.pop_front();
    checks++;
    if (light !== want) begin
      errors++;
      $display("[TB] FAIL async_on got %b want %b", light, want);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (light !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_drop got %b want 0", light);
    end
    #2 rstN = 1'b1;
    expQ.push_back(1'b1);
    @(posedge clk);
    #1;
    want = expQ.pop_front();
    checks++;
    if (light !== want) begin
      errors++;
      $display("[TB] FAIL async_release got %b want %b", light, want);
    end
  endtask

  task automatic test_param_equal();
    logic [7:0] lumTab[5] = '{8'd100, 8'd99, 8'd100, 8'd101, 8'd100};
    logic       expTab[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic want;
    for (int i = 0; i < 5; i++) begin
      lum100 = lumTab[i];
      expQ.push_back(expTab[i]);
      @(posedge clk);
      #1;
      want = expQ.pop_front();
      checks++;
      if (light100 !== want) begin
        errors++;
        $display("[TB] FAIL param100[%0d] lum=%0d got %b want %b", i, lumTab[i], light100, want);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequence();
    test_hysteresis();
    test_extremes();
    test_async_reset();
    test_param_equal();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
